// File: rtl/async_fifo_lvl.sv
// Dual-clock FIFO, clk_a writes and clk_b reads, Gray-coded pointer crossing.
// Adds per-side fill levels, almost-full/almost-empty flags and overflow/underflow pulses.
module async_fifo_lvl #(
    parameter  int FIFO_DEPTH    = 8,
    parameter  int DATA_WIDTH    = 64,
    parameter  int SYNC_STAGES   = 2,
    parameter  int AFULL_THRESH  = FIFO_DEPTH - 2,
    parameter  int AEMPTY_THRESH = 2,
    localparam int ADDR_W        = $clog2(FIFO_DEPTH)
) (
    input  logic                  clk_a,
    input  logic                  rst_a,
    input  logic                  clk_b,
    input  logic                  rst_b,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  wr_en,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_W:0]       wr_level,
    output logic                  overflow,
    output logic [DATA_WIDTH-1:0] dout,
    input  logic                  rd_en,
    output logic                  empty,
    output logic                  almost_empty,
    output logic [ADDR_W:0]       rd_level,
    output logic                  underflow
);
    localparam logic [ADDR_W:0] AF_L = AFULL_THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] AE_L = AEMPTY_THRESH[ADDR_W:0];

    function automatic logic [ADDR_W:0] g2b(input logic [ADDR_W:0] g);
        logic [ADDR_W:0] b;
        b[ADDR_W] = g[ADDR_W];
        for (int i = ADDR_W - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

    // ---------------- write domain ----------------
    logic [ADDR_W:0]                    wbin, wgray, wbin_nxt, wgray_nxt;
    logic [SYNC_STAGES-1:0][ADDR_W:0]   rq;
    logic [ADDR_W:0]                    rgray_sync, full_cmp;
    logic                               winc;

    assign winc       = wr_en & ~full;
    assign wbin_nxt   = wbin + {{ADDR_W{1'b0}}, winc};
    assign wgray_nxt  = wbin_nxt ^ (wbin_nxt >> 1);
    assign rgray_sync = rq[SYNC_STAGES-1];
    // Full when the writer is exactly one lap ahead of the synced read pointer.
    assign full_cmp   = {~rgray_sync[ADDR_W:ADDR_W-1], rgray_sync[ADDR_W-2:0]};

    always_ff @(posedge clk_a or negedge rst_a) begin
        if (!rst_a) begin
            wbin     <= '0;
            wgray    <= '0;
            rq       <= '0;
            full     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            wbin     <= wbin_nxt;
            wgray    <= wgray_nxt;
            rq       <= {rq[SYNC_STAGES-2:0], rgray};
            full     <= (wgray_nxt == full_cmp);
            overflow <= wr_en & full;
        end
    end

    always_ff @(posedge clk_a) begin
        if (winc) mem[wbin[ADDR_W-1:0]] <= din;
    end

    assign wr_level    = wbin - g2b(rgray_sync);
    assign almost_full = (wr_level >= AF_L);

    // ---------------- read domain ----------------
    logic [ADDR_W:0]                    rbin, rgray, rbin_nxt, rgray_nxt;
    logic [SYNC_STAGES-1:0][ADDR_W:0]   wq;
    logic [ADDR_W:0]                    wgray_sync;
    logic                               rinc;

    assign rinc       = rd_en & ~empty;
    assign rbin_nxt   = rbin + {{ADDR_W{1'b0}}, rinc};
    assign rgray_nxt  = rbin_nxt ^ (rbin_nxt >> 1);
    assign wgray_sync = wq[SYNC_STAGES-1];

    always_ff @(posedge clk_b or negedge rst_b) begin
        if (!rst_b) begin
            rbin      <= '0;
            rgray     <= '0;
            wq        <= '0;
            empty     <= 1'b1;
            underflow <= 1'b0;
        end else begin
            rbin      <= rbin_nxt;
            rgray     <= rgray_nxt;
            wq        <= {wq[SYNC_STAGES-2:0], wgray};
            empty     <= (rgray_nxt == wgray_sync);
            underflow <= rd_en & empty;
        end
    end

    // First-word fall-through: head entry is always presented.
    assign dout         = mem[rbin[ADDR_W-1:0]];
    assign rd_level     = g2b(wgray_sync) - rbin;
    assign almost_empty = (rd_level <= AE_L);

endmodule

// File: doc/async_fifo_lvl.md
Name: async_fifo_lvl

Overview:
- Parametrised dual-clock FIFO that moves DATA_WIDTH words from a write domain (clk_a) to a read domain (clk_b).
- Pointers cross domains as Gray code through SYNC_STAGES-deep synchronisers.
- Adds per-side fill levels, programmable almost-full/almost-empty flags, and sticky-free overflow/underflow error pulses.
- Sits at every clock-domain crossing in the design, replacing the basic async FIFO.

Parameters:
- FIFO_DEPTH, 8, entries; power of 2, >= 4; ADDR_W = $clog2(FIFO_DEPTH).
- DATA_WIDTH, 64, word width in bits.
- SYNC_STAGES, 2, flops per pointer synchroniser; legal range 2..4.
- AFULL_THRESH, FIFO_DEPTH-2, almost_full asserts when wr_level >= this value.
- AEMPTY_THRESH, 2, almost_empty asserts when rd_level <= this value.

Ports:
- clk_a  in  1  write-domain clock
- rst_a  in  1  write-domain reset, asynchronous, active-low
- clk_b  in  1  read-domain clock
- rst_b  in  1  read-domain reset, asynchronous, active-low
- din  in  DATA_WIDTH  write data
- wr_en  in  1  write request
- full  out  1  no free entry (clk_a)
- almost_full  out  1  wr_level >= AFULL_THRESH (clk_a)
- wr_level  out  ADDR_W+1  occupancy seen from write side, 0..FIFO_DEPTH
- overflow  out  1  one-cycle pulse: wr_en while full
- dout  out  DATA_WIDTH  head-of-queue data (first-word fall-through)
- rd_en  in  1  pop request
- empty  out  1  no valid entry (clk_b)
- almost_empty  out  1  rd_level <= AEMPTY_THRESH (clk_b)
- rd_level  out  ADDR_W+1  occupancy seen from read side
- underflow  out  1  one-cycle pulse: rd_en while empty

Behaviour:
- Storage: FIFO_DEPTH x DATA_WIDTH array written on clk_a, read asynchronously at the read address.
- Pointers: wbin/rbin are ADDR_W+1 bits. Each has a registered Gray copy, gray = bin ^ (bin >> 1). Only the Gray registers cross domains.
- Synchronisers: rgray goes through SYNC_STAGES flops on clk_a (reset by rst_a). wgray goes through SYNC_STAGES flops on clk_b (reset by rst_b). Synced Gray values are converted to binary locally.
- Write: on clk_a edge with wr_en && !full, store mem[wbin[ADDR_W-1:0]] <= din and increment wbin.
  - wr_en && full: no write, no pointer change; overflow = 1 for exactly the next clk_a cycle.
- Full (registered): asserted when next wgray equals rgray_sync with its two MSBs inverted and the remaining bits equal.
- Read: dout = mem[rbin[ADDR_W-1:0]]; valid whenever empty = 0.
  - On clk_b edge with rd_en && !empty: increment rbin; the next word appears on dout the same edge.
  - rd_en && empty: no change; underflow pulses for one clk_b cycle. dout is don't-care while empty.
- Empty (registered): asserted when next rgray == wgray_sync.
- Levels, combinational from registered pointers, modulo 2^(ADDR_W+1):
  - wr_level = wbin - bin(rgray_sync); pessimistic, overstates occupancy.
  - rd_level = bin(wgray_sync) - rbin; pessimistic, understates occupancy.
  - almost_full and almost_empty are compares on these levels.
- Crossing latency:
  - A write on clk_a edge N deasserts empty on clk_b edge SYNC_STAGES+1 after the first clk_b edge following N, tolerance +1 clk_b.
  - Symmetric for a read releasing full, counted in clk_a edges.
  - Flags never assert late: full and empty are always conservative.
- Wrap-around: the extra pointer MSB distinguishes full from empty. Operation continues across arbitrarily many wraps with no data loss.
- Simultaneous write and read, each side in its own domain: both proceed. Levels converge after the sync latency.
- Reset values, both domains:
  - Write side: wbin = wgray = 0, rgray_sync = 0, full = 0, almost_full = (0 >= AFULL_THRESH), wr_level = 0, overflow = 0.
  - Read side: rbin = rgray = 0, wgray_sync = 0, empty = 1, almost_empty = 1, rd_level = 0, underflow = 0.
  - Memory is not reset.
- Reset mid-operation: rst_a and rst_b must overlap by at least one period of the slower clock. After both release, the FIFO is empty and all prior contents are discarded. Asserting only one side is unsupported; no flag guarantees apply until both are reset.

Test Plan (DEPTH=8, DATA=64, SYNC=2, AFULL=6, AEMPTY=2; clk_a 10 ns, clk_b 17 ns):
- Reset both, write 0x1..0x8 back-to-back with no reads -> full=1 after the 8th write, wr_level=8, almost_full=1 from wr_level=6. A 9th wr_en gives a one-cycle overflow pulse; wr_level stays 8.
- Drain the full FIFO with rd_en held -> dout sequence 0x1..0x8 in order; empty=1 after the 8th pop. An extra rd_en gives a one-cycle underflow pulse.
- Single write of 0xDEAD into an empty FIFO -> empty deasserts within 3..4 clk_b edges; dout=0xDEAD; rd_level=1, almost_empty=1.
- Continuous random write/read with 25% stalls over 1000 words (many wraps) -> scoreboard matches exactly; full and empty are never both 1 on a true-empty or true-full FIFO.
- Reset both mid-stream with 5 entries held -> after release: empty=1, full=0, both levels 0. The next written word 0xA5 is the first read.
- Swap clocks (clk_a 17 ns, clk_b 10 ns) and repeat the random scenario -> zero mismatches; no overflow or underflow pulses when the flags are honoured.
